sq_fwd: RTL and testbench

- Parametrised store queue with store-to-load forwarding; the next-generation store half of the load-store queue.
- Stores are inserted in program order from rename. Each entry captures base and data operands from the writeback bus and generates its address internally.
- Entries become committable on ROB store retirement and drain in order to the dcache.
- A combinational query port tells a load whether older stores forward its data, conflict with it, or neither.

---
 rtl/sq_fwd.sv | 220 ++++++++++++++++++++++
 tb/tb_sq_fwd.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sq_fwd.sv
// sq_fwd: store queue with store-to-load forwarding.
//
// Stores enter in program order at tail, wait for their base/data operands
// on the writeback bus, compute their address through a single shared adder,
// become committable when the ROB retires them (mid), and drain in order to
// the dcache from head. A combinational port answers load lookups.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   ins_*                  insert from rename; ins_sqid is the tail pointer
//   wb_*                   writeback bus for operand capture
//   rob_ret_store          retire oldest unretired store (advance mid)
//   rob_flush              squash unretired stores (tail <= mid)
//   sq_dc_*, dcache_ready  in-order drain to the dcache
//   ld_query_*, ld_fwd_*, ld_conflict   forwarding lookup
//   sq_empty, sq_count     occupancy
module sq_fwd #(
    parameter int DEPTH = 16,
    parameter int IDW   = $clog2(DEPTH),
    parameter int TAGW  = 7
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ins_valid,
    output logic           ins_ready,
    input  logic [1:0]     ins_size,
    input  logic           ins_base_ready,
    input  logic [31:0]    ins_base,
    input  logic           ins_data_ready,
    input  logic [31:0]    ins_data,
    input  logic [31:0]    ins_imm,
    output logic [IDW:0]   ins_sqid,
    input  logic           wb_valid,
    input  logic           wb_error,
    input  logic [TAGW-1:0] wb_robid,
    input  logic [31:0]    wb_result,
    input  logic           rob_ret_store,
    input  logic           rob_flush,
    output logic           sq_dc_req,
    output logic [31:0]    sq_dc_addr,
    output logic [31:0]    sq_dc_wdata,
    output logic [3:0]     sq_dc_wmask,
    input  logic           dcache_ready,
    input  logic           ld_query_valid,
    input  logic [31:0]    ld_query_addr,
    input  logic [1:0]     ld_query_size,
    input  logic [IDW:0]   ld_query_sqid,
    output logic           ld_fwd_hit,
    output logic [31:0]    ld_fwd_data,
    output logic           ld_conflict,
    output logic           sq_empty,
    output logic [IDW:0]   sq_count
);
    localparam int PW = IDW + 1;

    function automatic logic [3:0] f_mask(input logic [1:0] sz, input logic [1:0] a);
        case (sz)
            2'd0:    f_mask = 4'b0001 << a;
            2'd1:    f_mask = 4'b0011 << a;
            default: f_mask = 4'hF;
        endcase
    endfunction

    logic [DEPTH-1:0] r_vld, r_base_rdy, r_data_rdy, r_addr_rdy;
    logic [31:0]      r_base [DEPTH];
    logic [31:0]      r_data [DEPTH];
    logic [31:0]      r_imm  [DEPTH];
    logic [31:0]      r_addr [DEPTH];
    logic [1:0]       r_size [DEPTH];
    logic [PW-1:0]    r_head, r_mid, r_tail;
    logic             r_agu_vld;
    logic [IDW-1:0]   r_agu_idx;

    logic             w_full, w_ins_fire, w_ret, w_drain;
    logic [PW-1:0]    w_mid_nxt, w_sq_len, w_older_len;
    logic [IDW-1:0]   w_hidx, w_tidx;
    logic [DEPTH-1:0] w_kill, w_cap_base, w_cap_data, w_agu_hit, w_cand;
    logic [3:0]       w_mask [DEPTH];
    logic [31:0]      w_lane [DEPTH];

    assign w_hidx     = r_head[IDW-1:0];
    assign w_tidx     = r_tail[IDW-1:0];
    assign w_full     = (w_tidx == w_hidx) & (r_tail[IDW] != r_head[IDW]);
    assign ins_ready  = ~w_full & ~rob_flush;
    assign w_ins_fire = ins_valid & ins_ready;
    assign ins_sqid   = r_tail;
    // An illegal retire (nothing unretired) is dropped rather than corrupting mid.
    assign w_ret      = rob_ret_store & (r_mid != r_tail);
    assign w_mid_nxt  = r_mid + PW'(w_ret);
    // Flush squashes [new mid, tail); a same-cycle retire is kept.
    assign w_sq_len   = r_tail - w_mid_nxt;
    assign sq_count   = r_tail - r_head;
    assign sq_empty   = (r_head == r_tail);

    for (genvar g = 0; g < DEPTH; g++) begin : g_ent
        logic [IDW-1:0] w_off;
        assign w_off         = IDW'(g) - w_mid_nxt[IDW-1:0];
        assign w_kill[g]     = rob_flush & ({1'b0, w_off} < w_sq_len);
        assign w_cap_base[g] = wb_valid & ~wb_error & r_vld[g] & ~r_base_rdy[g]
                             & (r_base[g][TAGW-1:0] == wb_robid);
        assign w_cap_data[g] = wb_valid & ~wb_error & r_vld[g] & ~r_data_rdy[g]
                             & (r_data[g][TAGW-1:0] == wb_robid);
        assign w_agu_hit[g]  = r_agu_vld & (r_agu_idx == IDW'(g)) & r_vld[g];
        // Last cycle's pick is still in flight, so skip it to avoid a double issue.
        assign w_cand[g]     = r_vld[g] & r_base_rdy[g] & ~r_addr_rdy[g]
                             & ~(r_agu_vld & (r_agu_idx == IDW'(g)));
        assign w_mask[g]     = f_mask(r_size[g], r_addr[g][1:0]);
        assign w_lane[g]     = r_data[g] << {r_addr[g][1:0], 3'b000};
    end

    // Lowest-index candidate wins the address adder.
    logic           w_pick_vld;
    logic [IDW-1:0] w_pick_idx;
    always_comb begin
        w_pick_vld = 1'b0;
        w_pick_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (w_cand[i]) begin
                w_pick_vld = 1'b1;
                w_pick_idx = IDW'(i);
            end
        end
    end

    assign sq_dc_req   = (r_head != r_mid) & r_addr_rdy[w_hidx] & r_data_rdy[w_hidx];
    assign sq_dc_addr  = {r_addr[w_hidx][31:2], 2'b00};
    assign sq_dc_wdata = w_lane[w_hidx];
    assign sq_dc_wmask = w_mask[w_hidx];
    assign w_drain     = sq_dc_req & dcache_ready;

    // Control state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld      <= '0;
            r_base_rdy <= '0;
            r_data_rdy <= '0;
            r_addr_rdy <= '0;
            r_head     <= '0;
            r_mid      <= '0;
            r_tail     <= '0;
            r_agu_vld  <= 1'b0;
            r_agu_idx  <= '0;
        end else begin
            r_agu_vld <= w_pick_vld;
            r_agu_idx <= w_pick_idx;
            for (int i = 0; i < DEPTH; i++) begin
                if (w_ins_fire && w_tidx == IDW'(i)) begin
                    r_vld[i]      <= 1'b1;
                    r_base_rdy[i] <= ins_base_ready;
                    r_data_rdy[i] <= ins_data_ready;
                    r_addr_rdy[i] <= 1'b0;
                end else begin
                    if (w_cap_base[i]) r_base_rdy[i] <= 1'b1;
                    if (w_cap_data[i]) r_data_rdy[i] <= 1'b1;
                    if (w_agu_hit[i])  r_addr_rdy[i] <= 1'b1;
                    if (w_kill[i] || (w_drain && w_hidx == IDW'(i))) r_vld[i] <= 1'b0;
                end
            end
            if (w_ins_fire) r_tail <= r_tail + PW'(1);
            if (rob_flush)  r_tail <= w_mid_nxt;
            r_mid <= w_mid_nxt;
            if (w_drain)    r_head <= r_head + PW'(1);
        end
    end

    // Payload; only meaningful while the matching valid/ready bit is set.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (w_ins_fire && w_tidx == IDW'(i)) begin
                r_base[i] <= ins_base;
                r_data[i] <= ins_data;
                r_imm[i]  <= ins_imm;
                r_size[i] <= ins_size;
            end else begin
                if (w_cap_base[i]) r_base[i] <= wb_result;
                if (w_cap_data[i]) r_data[i] <= wb_result;
                if (w_agu_hit[i])  r_addr[i] <= r_base[i] + r_imm[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && rob_ret_store)
            assert (r_mid != r_tail) else $error("sq_fwd: store retire with no unretired store");
    end

    // Forwarding scan, oldest to youngest so the last match is the youngest.
    logic [3:0]     w_ld_mask;
    logic           w_unres, w_match;
    logic [IDW-1:0] w_midx, w_sidx;
    logic           w_cover, w_hit;
    assign w_ld_mask   = f_mask(ld_query_size, ld_query_addr[1:0]);
    assign w_older_len = ld_query_sqid - r_head;

    always_comb begin
        w_unres = 1'b0;
        w_match = 1'b0;
        w_midx  = '0;
        w_sidx  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_sidx = w_hidx + IDW'(k);
            if (PW'(k) < w_older_len && r_vld[w_sidx]) begin
                if (!r_addr_rdy[w_sidx]) begin
                    w_unres = 1'b1;
                end else if (r_addr[w_sidx][31:2] == ld_query_addr[31:2]
                             && |(w_mask[w_sidx] & w_ld_mask)) begin
                    w_match = 1'b1;
                    w_midx  = w_sidx;
                end
            end
        end
    end

    assign w_cover     = ((w_mask[w_midx] & w_ld_mask) == w_ld_mask) & r_data_rdy[w_midx];
    assign w_hit       = ld_query_valid & ~w_unres & w_match & w_cover;
    assign ld_fwd_hit  = w_hit;
    assign ld_fwd_data = w_hit ? w_lane[w_midx] : 32'h0;
    assign ld_conflict = ld_query_valid & (w_unres | (w_match & ~w_cover));

endmodule

// File: tb/tb_sq_fwd.sv
module tb_sq_fwd;
    localparam int DEPTH = 16;
    localparam int IDW   = 4;
    localparam int TAGW  = 7;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ins_valid = 0, ins_ready, ins_base_ready = 0, ins_data_ready = 0;
    logic [1:0] ins_size = 0;
    logic [31:0] ins_base = 0, ins_data = 0, ins_imm = 0;
    logic [IDW:0] ins_sqid;
    logic wb_valid = 0, wb_error = 0;
    logic [TAGW-1:0] wb_robid = 0;
    logic [31:0] wb_result = 0;
    logic rob_ret_store = 0, rob_flush = 0;
    logic sq_dc_req, dcache_ready = 1;
    logic [31:0] sq_dc_addr, sq_dc_wdata;
    logic [3:0] sq_dc_wmask;
    logic ld_query_valid = 0;
    logic [31:0] ld_query_addr = 0;
    logic [1:0] ld_query_size = 0;
    logic [IDW:0] ld_query_sqid = 0;
    logic ld_fwd_hit, ld_conflict;
    logic [31:0] ld_fwd_data;
    logic sq_empty;
    logic [IDW:0] sq_count;

    sq_fwd #(.DEPTH(DEPTH), .IDW(IDW), .TAGW(TAGW)) dut (
        .clk(clk), .rst(rst),
        .ins_valid(ins_valid), .ins_ready(ins_ready), .ins_size(ins_size),
        .ins_base_ready(ins_base_ready), .ins_base(ins_base),
        .ins_data_ready(ins_data_ready), .ins_data(ins_data), .ins_imm(ins_imm),
        .ins_sqid(ins_sqid),
        .wb_valid(wb_valid), .wb_error(wb_error), .wb_robid(wb_robid), .wb_result(wb_result),
        .rob_ret_store(rob_ret_store), .rob_flush(rob_flush),
        .sq_dc_req(sq_dc_req), .sq_dc_addr(sq_dc_addr), .sq_dc_wdata(sq_dc_wdata),
        .sq_dc_wmask(sq_dc_wmask), .dcache_ready(dcache_ready),
        .ld_query_valid(ld_query_valid), .ld_query_addr(ld_query_addr),
        .ld_query_size(ld_query_size), .ld_query_sqid(ld_query_sqid),
        .ld_fwd_hit(ld_fwd_hit), .ld_fwd_data(ld_fwd_data), .ld_conflict(ld_conflict),
        .sq_empty(sq_empty), .sq_count(sq_count)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; logic [31:0] wdata; logic [3:0] mask; } dexp_t;
    typedef struct { logic hit; logic conf; logic [31:0] data; } qexp_t;
    dexp_t dq[$];
    qexp_t qq[$];
    int n_vec = 0;
    int n_err = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    // Monitor: pops the scoreboard whenever the DUT presents a drain beat or a query answer.
    always @(negedge clk) begin
        if (!rst && sq_dc_req && dcache_ready) begin
            if (dq.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL drain_unexpected: got addr %h data %h mask %h expected no request",
                         sq_dc_addr, sq_dc_wdata, sq_dc_wmask);
            end else begin
                dexp_t e;
                e = dq.pop_front();
                chk("drain_addr", sq_dc_addr, e.addr);
                chk("drain_wdata", sq_dc_wdata, e.wdata);
                chk("drain_mask", {28'h0, sq_dc_wmask}, {28'h0, e.mask});
            end
        end
        if (!rst && ld_query_valid) begin
            if (qq.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL query_unexpected: got a query with no expectation queued");
            end else begin
                qexp_t q;
                q = qq.pop_front();
                chk("ld_fwd_hit", {31'h0, ld_fwd_hit}, {31'h0, q.hit});
                chk("ld_conflict", {31'h0, ld_conflict}, {31'h0, q.conf});
                if (q.hit) chk("ld_fwd_data", ld_fwd_data, q.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic push_d(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        dexp_t e;
        e.addr = a; e.wdata = d; e.mask = m;
        dq.push_back(e);
    endtask

    task automatic do_ins(input logic [1:0] sz, input logic brdy, input logic [31:0] base,
                          input logic drdy, input logic [31:0] data, input logic [31:0] imm,
                          input logic [IDW:0] exp_id);
        ins_valid = 1; ins_size = sz; ins_base_ready = brdy; ins_base = base;
        ins_data_ready = drdy; ins_data = data; ins_imm = imm;
        @(negedge clk);
        chk("ins_ready", {31'h0, ins_ready}, 32'h1);
        chk("ins_sqid", {27'h0, ins_sqid}, {27'h0, exp_id});
        tick();
        ins_valid = 0;
    endtask

    task automatic retire(input int n);
        rob_ret_store = 1;
        repeat (n) tick();
        rob_ret_store = 0;
    endtask

    task automatic wb(input logic [TAGW-1:0] tag, input logic [31:0] res, input logic err);
        wb_valid = 1; wb_robid = tag; wb_result = res; wb_error = err;
        tick();
        wb_valid = 0; wb_error = 0;
    endtask

    task automatic wait_empty(input string nm);
        int n;
        n = 0;
        while (!sq_empty && n < 200) begin tick(); n++; end
        chk(nm, {31'h0, sq_empty}, 32'h1);
    endtask

    task automatic query(input logic [31:0] a, input logic [1:0] sz, input logic [IDW:0] id,
                         input logic h, input logic c, input logic [31:0] d);
        qexp_t q;
        q.hit = h; q.conf = c; q.data = d;
        qq.push_back(q);
        ld_query_valid = 1; ld_query_addr = a; ld_query_size = sz; ld_query_sqid = id;
        @(negedge clk);
        tick();
        ld_query_valid = 0;
    endtask

    initial begin
        // Reset state
        repeat (2) tick();
        rst = 0;
        @(negedge clk);
        chk("rst_ins_ready", {31'h0, ins_ready}, 32'h1);
        chk("rst_empty", {31'h0, sq_empty}, 32'h1);
        chk("rst_count", {27'h0, sq_count}, 32'h0);
        chk("rst_dc_req", {31'h0, sq_dc_req}, 32'h0);
        chk("rst_fwd_hit", {31'h0, ld_fwd_hit}, 32'h0);
        chk("rst_conflict", {31'h0, ld_conflict}, 32'h0);
        tick();

        // Word store: address becomes ready two cycles after insert
        push_d(32'h1004, 32'hDEADBEEF, 4'hF);
        do_ins(2'd2, 1, 32'h1000, 1, 32'hDEADBEEF, 32'h4, 5'd0);
        rob_ret_store = 1;
        @(negedge clk);
        chk("agu_lat0", {31'h0, sq_dc_req}, 32'h0);
        tick();
        rob_ret_store = 0;
        @(negedge clk);
        chk("agu_lat1", {31'h0, sq_dc_req}, 32'h0);
        tick();
        @(negedge clk);
        chk("agu_lat2", {31'h0, sq_dc_req}, 32'h1);
        tick();
        wait_empty("word_drain_empty");

        // Byte store, base captured from writeback
        push_d(32'h2000, 32'hAB000000, 4'b1000);
        do_ins(2'd0, 0, 32'h5, 1, 32'hAB, 32'h0, 5'd1);
        rob_ret_store = 1;
        wb(7'h05, 32'h2003, 0);
        rob_ret_store = 0;
        wait_empty("byte_drain_empty");

        // Writeback with error must not resolve the base
        do_ins(2'd0, 0, 32'h6, 1, 32'hCD, 32'h0, 5'd2);
        rob_ret_store = 1;
        wb(7'h06, 32'h3000, 1);
        rob_ret_store = 0;
        repeat (5) tick();
        @(negedge clk);
        chk("wberr_no_req", {31'h0, sq_dc_req}, 32'h0);
        chk("wberr_count", {27'h0, sq_count}, 32'h1);
        tick();
        push_d(32'h3000, 32'h00CD0000, 4'b0100);
        wb(7'h06, 32'h3002, 0);
        wait_empty("wberr_drain_empty");

        // Data operand captured from writeback
        push_d(32'h4000, 32'hCAFEF00D, 4'hF);
        do_ins(2'd2, 1, 32'h4000, 0, 32'h11, 32'h0, 5'd3);
        rob_ret_store = 1;
        wb(7'h11, 32'hCAFEF00D, 0);
        rob_ret_store = 0;
        wait_empty("data_wb_empty");

        // Fill with half stores, reject insert when full, drain, wrap
        for (int k = 0; k < DEPTH; k++) begin
            logic [31:0] d;
            d = 32'h1000 + k;
            push_d(32'h5000 + 32'(4 * (k / 2)), (k % 2 == 1) ? (d << 16) : d,
                   (k % 2 == 1) ? 4'b1100 : 4'b0011);
            do_ins(2'd1, 1, 32'h5000, 1, d, 32'(2 * k), 5'(4 + k));
        end
        @(negedge clk);
        chk("full_ins_ready", {31'h0, ins_ready}, 32'h0);
        chk("full_count", {27'h0, sq_count}, 32'd16);
        ins_valid = 1; ins_size = 2; ins_base_ready = 1; ins_base = 32'hF000;
        ins_data_ready = 1; ins_data = 32'hFFFFFFFF; ins_imm = 0;
        tick();
        ins_valid = 0;
        @(negedge clk);
        chk("full_count_hold", {27'h0, sq_count}, 32'd16);
        tick();
        retire(16);
        wait_empty("fill1_empty");
        chk("wrap_pol", {27'h0, ins_sqid}, 32'd20);
        chk("wrap_count", {27'h0, sq_count}, 32'd0);
        for (int k = 0; k < DEPTH; k++) begin
            push_d(32'h6000 + 32'(4 * k), 32'hA5000000 + k, 4'hF);
            do_ins(2'd2, 1, 32'h6000, 1, 32'hA5000000 + k, 32'(4 * k), 5'((20 + k) % 32));
        end
        @(negedge clk);
        chk("full2_count", {27'h0, sq_count}, 32'd16);
        tick();
        retire(16);
        wait_empty("fill2_empty");
        chk("wrap2_sqid", {27'h0, ins_sqid}, 32'd4);

        // Flush with same-cycle retire: 3 survive, 1 squashed, insert blocked
        for (int k = 0; k < 4; k++) begin
            if (k < 3) push_d(32'h7000 + 32'(4 * k), 32'h77000000 + k, 4'hF);
            do_ins(2'd2, 1, 32'h7000, 1, 32'h77000000 + k, 32'(4 * k), 5'(4 + k));
        end
        retire(2);
        rob_flush = 1; rob_ret_store = 1;
        ins_valid = 1; ins_size = 2; ins_base_ready = 1; ins_base = 32'h7100;
        ins_data_ready = 1; ins_data = 32'hEEEEEEEE; ins_imm = 0;
        @(negedge clk);
        chk("flush_ins_ready", {31'h0, ins_ready}, 32'h0);
        tick();
        rob_flush = 0; rob_ret_store = 0; ins_valid = 0;
        @(negedge clk);
        chk("flush_tail", {27'h0, ins_sqid}, 32'd7);
        tick();
        wait_empty("flush_empty");
        chk("flush_tail_after", {27'h0, ins_sqid}, 32'd7);

        // Forwarding queries
        push_d(32'h2000, 32'h11223344, 4'hF);
        do_ins(2'd2, 1, 32'h2000, 1, 32'h11223344, 32'h0, 5'd7);
        push_d(32'h2000, 32'h00005500, 4'b0010);
        do_ins(2'd0, 1, 32'h2000, 1, 32'h55, 32'h1, 5'd8);
        repeat (4) tick();
        query(32'h2000, 2'd2, 5'd9, 0, 1, 32'h0);
        query(32'h2001, 2'd0, 5'd9, 1, 0, 32'h00005500);
        query(32'h2000, 2'd0, 5'd9, 1, 0, 32'h11223344);
        query(32'h2001, 2'd0, 5'd8, 1, 0, 32'h11223344);
        query(32'h2000, 2'd2, 5'd7, 0, 0, 32'h0);
        query(32'h3000, 2'd2, 5'd9, 0, 0, 32'h0);
        ld_query_addr = 32'h2001; ld_query_size = 0; ld_query_sqid = 5'd9;
        @(negedge clk);
        chk("novalid_hit", {31'h0, ld_fwd_hit}, 32'h0);
        chk("novalid_conf", {31'h0, ld_conflict}, 32'h0);
        tick();
        push_d(32'h8000, 32'h0BADF00D, 4'hF);
        do_ins(2'd2, 0, 32'h22, 1, 32'h0BADF00D, 32'h0, 5'd9);
        query(32'h9000, 2'd2, 5'd10, 0, 1, 32'h0);
        query(32'h2001, 2'd0, 5'd9, 1, 0, 32'h00005500);
        wb(7'h22, 32'h8000, 0);
        repeat (3) tick();
        query(32'h9000, 2'd2, 5'd10, 0, 0, 32'h0);
        query(32'h8000, 2'd2, 5'd10, 1, 0, 32'h0BADF00D);
        query(32'h8002, 2'd1, 5'd10, 1, 0, 32'h0BADF00D);
        retire(3);
        wait_empty("fwd_empty");

        // Reset with a request outstanding
        dcache_ready = 0;
        do_ins(2'd2, 1, 32'hB000, 1, 32'h1, 32'h0, 5'd10);
        do_ins(2'd2, 1, 32'hB004, 1, 32'h2, 32'h0, 5'd11);
        retire(1);
        repeat (4) tick();
        @(negedge clk);
        chk("pre_rst_req", {31'h0, sq_dc_req}, 32'h1);
        tick();
        rst = 1;
        tick();
        rst = 0;
        @(negedge clk);
        chk("mid_rst_empty", {31'h0, sq_empty}, 32'h1);
        chk("mid_rst_count", {27'h0, sq_count}, 32'h0);
        chk("mid_rst_req", {31'h0, sq_dc_req}, 32'h0);
        chk("mid_rst_sqid", {27'h0, ins_sqid}, 32'h0);
        tick();
        dcache_ready = 1;
        push_d(32'hA000, 32'h12345678, 4'hF);
        do_ins(2'd2, 1, 32'hA000, 1, 32'h12345678, 32'h0, 5'd0);
        retire(1);
        wait_empty("post_rst_empty");
        repeat (3) tick();

        chk("drain_queue_left", dq.size(), 32'h0);
        chk("query_queue_left", qq.size(), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
